fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL take parameter PRECISION_LEN, default 64, operand/result width.
REQ-002 SHALL take parameter OP_LEN, default 4, operation-code width.
REQ-003 SHALL take parameter MIN_WAIT, default 3, WAIT cycles before fpu_valid is qualified.
REQ-004 SHALL take parameter TIMEOUT, default 63, WAIT cycles before abort; TIMEOUT > MIN_WAIT.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port srst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  in  2  per-requester request, held until accepted.
REQ-008 SHALL have port req_op  in  2*OP_LEN  packed op codes, requester n at bits [n*OP_LEN +: OP_LEN].
REQ-009 SHALL have port req_a  in  2*PRECISION_LEN  packed operand A per requester.
REQ-010 SHALL have port req_b  in  2*PRECISION_LEN  packed operand B per requester.
REQ-011 SHALL have port req_ready  out  2  one-cycle accept pulse per requester.
REQ-012 SHALL have port rsp_valid  out  2  one-cycle result strobe per requester.
REQ-013 SHALL have port rsp_result  out  PRECISION_LEN  shared result bus.
REQ-014 SHALL have port rsp_err  out  1  timeout flag, qualified by rsp_valid.
REQ-015 SHALL have ports fpu_a, fpu_b  out  PRECISION_LEN  operands to FPU controller.
REQ-016 SHALL have port fpu_operation  out  OP_LEN  op code to FPU controller.
REQ-017 SHALL have port fpu_enable  out  1  issue strobe to FPU controller.
REQ-018 SHALL have ports fpu_busy, fpu_valid  in  1 each; fpu_result  in  PRECISION_LEN.

Function
REQ-019 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; one operation outstanding at a time.
REQ-020 IDLE: if any req_valid, winner chosen by round-robin pointer; req_ready[winner]=1 that cycle; op/operands/owner captured; go ISSUE. No request: stay IDLE.
REQ-021 Both req_valid in same IDLE cycle: pointer holder wins; loser waits, req_ready low.
REQ-022 req_ready SHALL be 0 in every state except IDLE.
REQ-023 Captured op == 0 (IDLE code): go directly to RESP with rsp_result=0, rsp_err=0; no FPU activity.
REQ-024 ISSUE: if fpu_busy=1 stay ISSUE, fpu_enable=0; else fpu_enable=1 for exactly one cycle, go WAIT with wait_cnt=0.
REQ-025 fpu_operation, fpu_a, fpu_b SHALL hold captured values from ISSUE through WAIT; 0 in IDLE and RESP.
REQ-026 WAIT: wait_cnt increments each cycle; fpu_valid ignored while wait_cnt < MIN_WAIT.
REQ-027 WAIT, wait_cnt >= MIN_WAIT and fpu_valid=1: register fpu_result, rsp_err=0, go RESP.
REQ-028 WAIT, wait_cnt == TIMEOUT and no qualified fpu_valid: rsp_result=0, rsp_err=1, go RESP; valid wins if both in same cycle.
REQ-029 RESP: rsp_valid[owner]=1 one cycle, other bit 0; pointer set to non-owner; go IDLE.
REQ-030 rsp_result, rsp_err SHALL hold last values outside RESP.
REQ-031 Latency with fpu_busy=0: accept cycle T, ISSUE T+1, WAIT from T+2, earliest rsp_valid T+6 (MIN_WAIT=3).
REQ-032 Requester dropping req_valid before accept SHALL be ignored without side effects.

Reset
REQ-033 srst=1 at a clock edge SHALL force IDLE, pointer=0 (requester 0 first), wait_cnt=0, all outputs 0, including mid-operation; in-flight result discarded, no rsp_valid.
REQ-034 req_ready SHALL be 0 during any cycle srst=1.

Structure
REQ-035 Op-code constants (IDLE=0, ADD, SUB, MUL, DIV, SIN, COS, LOG, EXP, SQR) and FSM state encoding SHALL live in the shared FPU package/include used by the controller.
REQ-036 Round-robin selection SHALL be a sub-module rr_arbiter2 (2 requests, pointer, grant one-hot).

Verification
REQ-037 Req0 MUL a=0x4000000000000000 b=0x4008000000000000, fpu_valid=1 constant, fpu_result=0x4018000000000000 -> req_ready[0] at T, rsp_valid[0] at T+6, result 0x4018000000000000, rsp_err=0.
REQ-038 Both requesters valid from reset, DIV each -> req0 served first, req1 accepted in IDLE after req0 RESP, then pointer back to 0.
REQ-039 fpu_busy=1 for 10 cycles after accept -> fpu_enable stays 0 for 10 cycles, pulses once when busy drops.
REQ-040 fpu_valid never asserted -> rsp_valid at T+66, rsp_result=0, rsp_err=1.
REQ-041 Req1 op=0 -> rsp_valid[1] at T+2, result 0, fpu_enable never asserted.
REQ-042 srst asserted during WAIT -> next cycle IDLE, all outputs 0, no rsp_valid, pointer=0.

Source files
------------

// File: rtl/fpu_arbiter_pkg.sv
// Shared FPU op codes and arbiter FSM state encoding.
// Imported by the arbiter and the FPU controller.
package fpu_arbiter_pkg;

  localparam logic [3:0] OP_IDLE = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_SIN  = 4'd5;
  localparam logic [3:0] OP_COS  = 4'd6;
  localparam logic [3:0] OP_LOG  = 4'd7;
  localparam logic [3:0] OP_EXP  = 4'd8;
  localparam logic [3:0] OP_SQR  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } fpu_state_t;

endpackage

// File: rtl/fpu_arbiter_rr.sv
// Two-way round-robin grant: pointer holder wins ties.
// Ports: req (2 requests), ptr (priority owner), gnt (one-hot).
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (ptr) begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end else begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one FPU controller between two requesters.
// Ports: req_* in / req_ready, rsp_* out; fpu_* to/from FPU ctrl.
module fpu_arbiter
  import fpu_arbiter_pkg::*;
#(
  parameter int PRECISION_LEN = 64,
  parameter int OP_LEN        = 4,
  parameter int MIN_WAIT      = 3,
  parameter int TIMEOUT       = 63
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic [1:0]                 req_valid,
  input  logic [2*OP_LEN-1:0]        req_op,
  input  logic [2*PRECISION_LEN-1:0] req_a,
  input  logic [2*PRECISION_LEN-1:0] req_b,
  output logic [1:0]                 req_ready,
  output logic [1:0]                 rsp_valid,
  output logic [PRECISION_LEN-1:0]   rsp_result,
  output logic                       rsp_err,
  output logic [PRECISION_LEN-1:0]   fpu_a,
  output logic [PRECISION_LEN-1:0]   fpu_b,
  output logic [OP_LEN-1:0]          fpu_operation,
  output logic                       fpu_enable,
  input  logic                       fpu_busy,
  input  logic                       fpu_valid,
  input  logic [PRECISION_LEN-1:0]   fpu_result
);

  localparam int CW = $clog2(TIMEOUT + 1);

  fpu_state_t                 state_q, state_d;
  logic                       ptr_q;
  logic                       owner_q;
  logic [OP_LEN-1:0]          op_q;
  logic [PRECISION_LEN-1:0]   a_q, b_q;
  logic [CW-1:0]              cnt_q;
  logic [PRECISION_LEN-1:0]   res_q;
  logic                       err_q;
  logic [1:0]                 gnt;
  logic                       win;
  logic                       nop;
  logic                       qual;
  logic                       tmo;

  rr_arbiter2 u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign win  = gnt[1];
  assign nop  = (op_q == OP_LEN'(OP_IDLE));
  assign qual = fpu_valid && (cnt_q >= CW'(MIN_WAIT));
  assign tmo  = (cnt_q == CW'(TIMEOUT));

  assign rsp_result = res_q;
  assign rsp_err    = err_q;

  always_comb begin
    state_d       = state_q;
    req_ready     = 2'b00;
    rsp_valid     = 2'b00;
    fpu_enable    = 1'b0;
    fpu_operation = '0;
    fpu_a         = '0;
    fpu_b         = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready = gnt;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (nop) begin
          state_d = ST_RESP;
        end else begin
          fpu_operation = op_q;
          fpu_a         = a_q;
          fpu_b         = b_q;
          if (!fpu_busy) begin
            fpu_enable = 1'b1;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        fpu_operation = op_q;
        fpu_a         = a_q;
        fpu_b         = b_q;
        if (qual || tmo) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Nothing may be accepted or reported while reset is held.
    if (srst) begin
      req_ready  = 2'b00;
      rsp_valid  = 2'b00;
      fpu_enable = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            owner_q <= win;
            op_q <= win ? req_op[OP_LEN +: OP_LEN]
                        : req_op[0 +: OP_LEN];
            a_q  <= win ? req_a[PRECISION_LEN +: PRECISION_LEN]
                        : req_a[0 +: PRECISION_LEN];
            b_q  <= win ? req_b[PRECISION_LEN +: PRECISION_LEN]
                        : req_b[0 +: PRECISION_LEN];
          end
        end
        ST_ISSUE: begin
          cnt_q <= '0;
          if (nop) begin
            res_q <= '0;
            err_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // A qualified result beats a timeout in the same cycle.
          if (qual) begin
            res_q <= fpu_result;
            err_q <= 1'b0;
          end else if (tmo) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        ST_RESP: ptr_q <= ~owner_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Randomized and directed bench for fpu_arbiter.
// Cycle-level reference model derived from the timing rules.
module tb_fpu_arbiter;

  localparam int PL = 64;
  localparam int OL = 4;
  localparam int MW = 3;
  localparam int TO = 63;

  logic          clk = 1'b0;
  logic          srst;
  logic [1:0]    req_valid;
  logic [2*OL-1:0] req_op;
  logic [2*PL-1:0] req_a, req_b;
  logic [1:0]    req_ready, rsp_valid;
  logic [PL-1:0] rsp_result, fpu_a, fpu_b, fpu_result;
  logic          rsp_err, fpu_enable, fpu_busy, fpu_valid;
  logic [OL-1:0] fpu_operation;

  fpu_arbiter #(
    .PRECISION_LEN(PL), .OP_LEN(OL),
    .MIN_WAIT(MW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .srst(srst),
    .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_operation(fpu_operation),
    .fpu_enable(fpu_enable), .fpu_busy(fpu_busy),
    .fpu_valid(fpu_valid), .fpu_result(fpu_result)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rdy_cyc[2], rdy_n[2], rsp_cyc[2], rsp_n[2];
  logic [PL-1:0] rsp_res[2];
  logic rsp_e[2];
  bit drop[2];
  int en_cnt, en_at, busy_len, busy_until, dly;
  bit en_seen, vconst;
  logic [OL-1:0] en_op;
  logic [PL-1:0] en_a, en_b;

  task automatic clr();
    for (int n = 0; n < 2; n++) begin
      rdy_cyc[n] = -1; rdy_n[n] = 0;
      rsp_cyc[n] = -1; rsp_n[n] = 0;
      rsp_res[n] = 'x; rsp_e[n] = 1'bx;
      drop[n] = 0;
    end
    en_cnt = 0; en_at = -1; en_seen = 0;
    busy_until = 0; en_op = '0; en_a = '0; en_b = '0;
  endtask

  // Observe one cycle at negedge, then advance inputs after posedge.
  task automatic tick();
    @(negedge clk);
    if (fpu_enable) begin
      en_cnt++; en_at = cyc; en_seen = 1;
      en_op = fpu_operation; en_a = fpu_a; en_b = fpu_b;
    end
    for (int n = 0; n < 2; n++) begin
      if (req_ready[n]) begin
        rdy_cyc[n] = cyc; rdy_n[n]++; drop[n] = 1;
        busy_until = cyc + 1 + busy_len;
      end
      if (rsp_valid[n]) begin
        rsp_cyc[n] = cyc; rsp_n[n]++;
        rsp_res[n] = rsp_result; rsp_e[n] = rsp_err;
        en_seen = 0;
      end
    end
    @(posedge clk); #1; cyc++;
    for (int n = 0; n < 2; n++)
      if (drop[n]) begin req_valid[n] = 1'b0; drop[n] = 0; end
    fpu_busy  = (cyc < busy_until);
    fpu_valid = vconst || (en_seen && (cyc - en_at >= dly));
  endtask

  task automatic start(input int n, input int op,
                       input logic [PL-1:0] a, input logic [PL-1:0] b);
    req_op[n*OL +: OL] = OL'(op);
    req_a[n*PL +: PL]  = a;
    req_b[n*PL +: PL]  = b;
    req_valid[n] = 1'b1;
  endtask

  task automatic wait_rsp(input int n);
    for (int k = 0; k < 300 && rsp_n[n] == 0; k++) tick();
  endtask

  // FPU raises valid d cycles after the enable cycle e; WAIT count k
  // lives in cycle e+1+k and qualifies once k >= MW.
  function automatic void model(input int t, input int op,
      input int busy, input int d,
      output int rc, output bit err, output int ne);
    int e, k;
    if (op == 0) begin
      rc = t + 2; err = 0; ne = 0;
    end else begin
      e = t + 1 + busy; ne = 1;
      k = (d - 1 > MW) ? d - 1 : MW;
      if (k <= TO) begin rc = e + 2 + k; err = 0; end
      else begin rc = e + 2 + TO; err = 1; end
    end
  endfunction

  task automatic test_reset();
    srst = 1'b1; req_valid = 2'b11; req_op = 8'h33;
    clr(); tick(); tick();
    n_chk++;
    if (rdy_n[0] + rdy_n[1] != 0)
      $display("FAIL reset_ready got %0d want 0", rdy_n[0] + rdy_n[1]);
    else n_pass++;
    req_valid = 2'b00; srst = 1'b0; tick();
    n_chk++;
    if ({req_ready, rsp_valid, fpu_enable, fpu_operation,
         fpu_a, fpu_b, rsp_result, rsp_err} !== '0)
      $display("FAIL reset_outputs got %h/%h/%h/%h want 0",
               req_ready, rsp_valid, fpu_a, rsp_result);
    else n_pass++;
  endtask

  task automatic test_op0();
    int s;
    clr(); busy_len = 0; vconst = 0; dly = 1;
    start(1, 0, 64'h1234, 64'h5678); s = cyc;
    wait_rsp(1); tick(); tick();
    n_chk++;
    if (rdy_cyc[1] != s || rsp_cyc[1] != s + 2)
      $display("FAIL op0_timing got %0d/%0d want %0d/%0d",
               rdy_cyc[1] - s, rsp_cyc[1] - s, 0, 2);
    else n_pass++;
    n_chk++;
    if (rsp_res[1] !== '0 || rsp_e[1] !== 1'b0)
      $display("FAIL op0_result got %h/%b want 0/0", rsp_res[1], rsp_e[1]);
    else n_pass++;
    n_chk++;
    if (en_cnt != 0 || rsp_n[0] != 0 || rsp_n[1] != 1)
      $display("FAIL op0_activity got en=%0d r0=%0d r1=%0d want 0/0/1",
               en_cnt, rsp_n[0], rsp_n[1]);
    else n_pass++;
  endtask

  task automatic test_mul();
    int s;
    clr(); vconst = 1; fpu_result = 64'h4018000000000000;
    start(0, 3, 64'h4000000000000000, 64'h4008000000000000);
    s = cyc; wait_rsp(0); tick(); vconst = 0;
    n_chk++;
    if (rdy_cyc[0] != s || rsp_cyc[0] != s + 6)
      $display("FAIL mul_timing got %0d/%0d want 0/6",
               rdy_cyc[0] - s, rsp_cyc[0] - s);
    else n_pass++;
    n_chk++;
    if (rsp_res[0] !== 64'h4018000000000000 || rsp_e[0] !== 1'b0)
      $display("FAIL mul_result got %h/%b want 4018000000000000/0",
               rsp_res[0], rsp_e[0]);
    else n_pass++;
    n_chk++;
    if (en_cnt != 1 || en_op !== 4'd3 ||
        en_a !== 64'h4000000000000000 || en_b !== 64'h4008000000000000)
      $display("FAIL mul_issue got en=%0d op=%h a=%h b=%h want 1/3/4000../4008..",
               en_cnt, en_op, en_a, en_b);
    else n_pass++;
    n_chk++;
    if (fpu_a !== '0 || fpu_operation !== '0 || rsp_result !== fpu_result)
      $display("FAIL mul_idle_hold got a=%h op=%h res=%h want 0/0/%h",
               fpu_a, fpu_operation, rsp_result, fpu_result);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    clr(); vconst = 0; dly = 1000;
    start(0, 1, 64'hAAAA, 64'hBBBB);
    repeat (5) tick();
    srst = 1'b1; tick(); srst = 1'b0;
    n_chk++;
    if ({req_ready, rsp_valid, fpu_enable, fpu_operation,
         fpu_a, fpu_b, rsp_result, rsp_err} !== '0)
      $display("FAIL midrst_outputs got %h/%h/%h/%h want 0",
               rsp_valid, fpu_operation, fpu_a, rsp_result);
    else n_pass++;
    repeat (70) tick();
    n_chk++;
    if (rsp_n[0] + rsp_n[1] != 0)
      $display("FAIL midrst_rsp got %0d want 0", rsp_n[0] + rsp_n[1]);
    else n_pass++;
    clr(); start(0, 1, 64'h1, 64'h2); start(1, 1, 64'h3, 64'h4);
    tick();
    n_chk++;
    if (rdy_n[0] != 1 || rdy_n[1] != 0)
      $display("FAIL midrst_ptr got %0d%0d want 10", rdy_n[0], rdy_n[1]);
    else n_pass++;
    srst = 1'b1; req_valid = 2'b00; tick(); srst = 1'b0;
    clr(); tick();
  endtask

  task automatic test_both();
    int s;
    clr(); vconst = 1; busy_len = 0; fpu_result = 64'h3FF0000000000000;
    srst = 1'b1;
    start(0, 4, 64'h10, 64'h20); start(1, 4, 64'h30, 64'h40);
    tick(); srst = 1'b0; s = cyc;
    wait_rsp(1);
    n_chk++;
    if (rdy_cyc[0] != s || rsp_cyc[0] != s + 6)
      $display("FAIL both_req0 got %0d/%0d want 0/6",
               rdy_cyc[0] - s, rsp_cyc[0] - s);
    else n_pass++;
    n_chk++;
    if (rdy_cyc[1] != s + 7 || rsp_cyc[1] != s + 13 || rdy_n[1] != 1)
      $display("FAIL both_req1 got %0d/%0d n=%0d want 7/13/1",
               rdy_cyc[1] - s, rsp_cyc[1] - s, rdy_n[1]);
    else n_pass++;
    clr(); start(0, 4, 64'h10, 64'h20); start(1, 4, 64'h30, 64'h40);
    tick();
    n_chk++;
    if (rdy_n[0] != 1 || rdy_n[1] != 0)
      $display("FAIL both_ptr_back got %0d%0d want 10", rdy_n[0], rdy_n[1]);
    else n_pass++;
    wait_rsp(1); vconst = 0;
  endtask

  task automatic test_busy();
    int s;
    clr(); vconst = 1; busy_len = 10;
    start(0, 2, 64'h77, 64'h88); s = cyc;
    wait_rsp(0); vconst = 0; busy_len = 0;
    n_chk++;
    if (en_cnt != 1 || en_at != s + 11)
      $display("FAIL busy_enable got n=%0d at=%0d want 1/11",
               en_cnt, en_at - s);
    else n_pass++;
    n_chk++;
    if (rsp_cyc[0] != s + 16)
      $display("FAIL busy_rsp got %0d want 16", rsp_cyc[0] - s);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int s;
    clr(); vconst = 0; dly = 1000; fpu_result = 64'hDEAD;
    start(1, 7, 64'h5, 64'h6); s = cyc;
    wait_rsp(1);
    n_chk++;
    if (rsp_cyc[1] != s + 66)
      $display("FAIL tmo_rsp got %0d want 66", rsp_cyc[1] - s);
    else n_pass++;
    n_chk++;
    if (rsp_res[1] !== '0 || rsp_e[1] !== 1'b1)
      $display("FAIL tmo_result got %h/%b want 0/1", rsp_res[1], rsp_e[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    int n, op, s, rc, ne;
    bit err;
    logic [PL-1:0] a, b, r, er;
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(2, 0)) tick();
      clr(); vconst = 0;
      n  = $urandom_range(1, 0);
      op = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(9, 1);
      busy_len = $urandom_range(4, 0);
      dly = ($urandom_range(4, 0) == 0) ? $urandom_range(80, 60)
                                        : $urandom_range(12, 1);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      r = {$urandom, $urandom}; fpu_result = r;
      start(n, op, a, b); s = cyc;
      model(s, op, busy_len, dly, rc, err, ne);
      er = (err || op == 0) ? '0 : r;
      wait_rsp(n);
      n_chk++;
      if (rdy_cyc[n] != s || rsp_cyc[n] != rc)
        $display("FAIL rnd%0d_timing got %0d/%0d want 0/%0d",
                 i, rdy_cyc[n] - s, rsp_cyc[n] - s, rc - s);
      else n_pass++;
      n_chk++;
      if (rsp_res[n] !== er || rsp_e[n] !== err)
        $display("FAIL rnd%0d_result got %h/%b want %h/%b",
                 i, rsp_res[n], rsp_e[n], er, err);
      else n_pass++;
      n_chk++;
      if (en_cnt != ne || rsp_n[1-n] != 0)
        $display("FAIL rnd%0d_activity got en=%0d other=%0d want %0d/0",
                 i, en_cnt, rsp_n[1-n], ne);
      else n_pass++;
      if (ne == 1) begin
        n_chk++;
        if (en_op !== OL'(op) || en_a !== a || en_b !== b)
          $display("FAIL rnd%0d_operands got %h/%h/%h want %h/%h/%h",
                   i, en_op, en_a, en_b, op, a, b);
        else n_pass++;
      end
    end
    busy_len = 0;
  endtask

  initial begin
    srst = 1'b1; req_valid = 2'b00; req_op = '0;
    req_a = '0; req_b = '0; fpu_result = '0;
    fpu_busy = 1'b0; fpu_valid = 1'b0;
    busy_len = 0; dly = 1; vconst = 0;
    clr();
    @(posedge clk); #1;
    test_reset();
    test_op0();
    test_mul();
    test_reset_midop();
    test_both();
    test_busy();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
